// File: rtl/program_loader.sv
// Packs a length-prefixed byte stream into 32-bit words and writes them to instruction RAM while holding the CPU off.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int MAX_WORDS = 256,
  parameter int CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [31:0]      Base_addr,
  input  logic [7:0]       Byte_in,
  input  logic             Byte_valid,
  output logic             Byte_ready,
  output logic             Enable,
  output logic             RW_ram,
  output logic [31:0]      Address_in,
  output logic [31:0]      In,
  output logic             Cpu_hold,
  output logic             Done,
  output logic             Error,
  output logic [CNT_W-1:0] Word_count
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LEN_HI = 3'd1, S_LEN_LO = 3'd2, S_BYTES = 3'd3,
    S_WRITE = 3'd4, S_CHK = 3'd5, S_DONE = 3'd6
  } state_t;
  localparam state_t S_END = S_CHK;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LEN_HI = 3'd1, S_LEN_LO = 3'd2, S_BYTES = 3'd3,
    S_WRITE = 3'd4, S_DONE = 3'd6
  } state_t;
  localparam state_t S_END = S_DONE;
`endif

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_base;
  logic [31:0]      r_word;
  logic [7:0]       r_len_hi;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_bcnt;
  logic             r_err;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       r_xor;
`endif

  logic        w_acc;
  logic [15:0] w_len;
  logic        w_len_over;
  logic        w_last;

  assign w_acc      = Byte_valid && Byte_ready;
  assign w_len      = {r_len_hi, Byte_in};
  assign w_len_over = 32'(w_len) > 32'(MAX_WORDS);
  // r_cnt still holds the index of the word being written during WRITE
  assign w_last     = (32'(r_cnt) + 32'd1) >= 32'(r_len);

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (Start) w_next = S_LEN_HI;
      S_LEN_HI: if (w_acc) w_next = S_LEN_LO;
      S_LEN_LO: begin
        if (w_acc) begin
          if (w_len == 16'd0)  w_next = S_END;
          else if (w_len_over) w_next = S_DONE;
          else                 w_next = S_BYTES;
        end
      end
      S_BYTES:  if (w_acc && r_bcnt == 2'd3) w_next = S_WRITE;
      S_WRITE:  w_next = w_last ? S_END : S_BYTES;
`ifdef LOADER_CHECKSUM_EN
      S_CHK:    if (w_acc) w_next = S_DONE;
`endif
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    Byte_ready = 1'b0;
    Enable     = 1'b0;
    RW_ram     = 1'b1;
    Address_in = 32'd0;
    In         = 32'd0;
    Cpu_hold   = 1'b1;
    Done       = 1'b0;
    case (r_state)
      S_IDLE:   Cpu_hold = 1'b0;
      S_LEN_HI, S_LEN_LO, S_BYTES: Byte_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHK:    Byte_ready = 1'b1;
`endif
      S_WRITE: begin
        Enable     = 1'b1;
        RW_ram     = 1'b0;
        Address_in = r_base + 32'(r_cnt);
        In         = r_word;
      end
      S_DONE: begin
        Done     = 1'b1;
        Cpu_hold = 1'b0;
      end
      default: ;
    endcase
  end

  assign Error      = r_err;
  assign Word_count = r_cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_base   <= 32'd0;
      r_word   <= 32'd0;
      r_len_hi <= 8'd0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_bcnt   <= 2'd0;
      r_err    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_xor    <= 8'd0;
`endif
    end else begin
`ifdef LOADER_CHECKSUM_EN
      if (w_acc && r_state != S_CHK) r_xor <= r_xor ^ Byte_in;
`endif
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_base <= Base_addr;
            r_cnt  <= '0;
            r_err  <= 1'b0;
            r_bcnt <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
            r_xor  <= 8'd0;
`endif
          end
        end
        S_LEN_HI: if (w_acc) r_len_hi <= Byte_in;
        S_LEN_LO: begin
          if (w_acc) begin
            r_len <= CNT_W'(w_len);
            if (w_len_over) r_err <= 1'b1;
          end
        end
        S_BYTES: begin
          if (w_acc) begin
            r_word <= {r_word[23:0], Byte_in};
            r_bcnt <= r_bcnt + 2'd1;
          end
        end
        S_WRITE: r_cnt <= r_cnt + CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
        S_CHK: if (w_acc && Byte_in != r_xor) r_err <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: write sequence, timing, overflow, reset abort, address wrap, optional checksum.
module tb_program_loader;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [31:0] Base_addr = 32'd0;
  logic [7:0]  Byte_in = 8'd0;
  logic        Byte_valid = 1'b0;
  logic        Byte_ready, Enable, RW_ram, Cpu_hold, Done, Error;
  logic [31:0] Address_in, In;
  logic [15:0] Word_count;

  program_loader #(.MAX_WORDS(256), .CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Base_addr(Base_addr),
    .Byte_in(Byte_in), .Byte_valid(Byte_valid), .Byte_ready(Byte_ready),
    .Enable(Enable), .RW_ram(RW_ram), .Address_in(Address_in), .In(In),
    .Cpu_hold(Cpu_hold), .Done(Done), .Error(Error), .Word_count(Word_count)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_viol = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  // RAM write log and port-safety watch, sampled mid-cycle
  always @(negedge Clk) begin
    if (Enable) begin
      wr_addr.push_back(Address_in);
      wr_data.push_back(In);
    end
    if ((Enable === RW_ram) || (Enable && (Byte_ready || !Cpu_hold))) n_viol++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] base);
    Base_addr = base;
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit rnd);
    int guard;
    guard = 0;
    Byte_in = b;
    forever begin
      Byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge Clk);
      if (Byte_valid && Byte_ready) break;
      tick();
      guard++;
      if (guard > 100) begin
        check_eq("byte_timeout", {31'd0, Byte_ready}, 32'd1);
        break;
      end
    end
    tick();
    Byte_valid = 1'b0;
  endtask

  function automatic logic [7:0] xsum(input logic [7:0] s[$]);
    logic [7:0] x;
    x = 8'd0;
    foreach (s[i]) x = x ^ s[i];
    return x;
  endfunction

  task automatic wait_done(input string tag);
    int g;
    g = 0;
    while (!Done && g < 20) begin
      tick();
      g++;
    end
    check_eq(tag, {31'd0, Done}, 32'd1);
  endtask

  task automatic load(input logic [31:0] base, input logic [7:0] s[$], input bit rnd);
    do_start(base);
    foreach (s[i]) push_byte(s[i], rnd);
`ifdef LOADER_CHECKSUM_EN
    push_byte(xsum(s), rnd);
`endif
    wait_done("load_done");
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
    if (idx < wr_addr.size()) begin
      check_eq({tag, "_addr"}, wr_addr[idx], a);
      check_eq({tag, "_data"}, wr_data[idx], d);
    end else begin
      check_eq({tag, "_missing"}, wr_addr.size(), idx + 1);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  logic [7:0] t1[$] = '{8'h00, 8'h02, 8'h06, 8'h28, 8'h00, 8'h60, 8'hE1, 8'h00, 8'h00, 8'h05};
  logic [7:0] t6[$] = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  logic [7:0] t5[$] = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    check_eq("rst_enable", {31'd0, Enable}, 32'd0);
    check_eq("rst_rw", {31'd0, RW_ram}, 32'd1);
    check_eq("rst_addr", Address_in, 32'd0);
    check_eq("rst_in", In, 32'd0);
    check_eq("rst_ready", {31'd0, Byte_ready}, 32'd0);
    check_eq("rst_hold", {31'd0, Cpu_hold}, 32'd0);
    check_eq("rst_done", {31'd0, Done}, 32'd0);
    check_eq("rst_err", {31'd0, Error}, 32'd0);
    check_eq("rst_cnt", 32'(Word_count), 32'd0);
    Reset = 1'b0;
    tick();

    // basic two-word load with cycle-exact checks
    clear_log();
    do_start(32'h10);
    check_eq("t1_hold", {31'd0, Cpu_hold}, 32'd1);
    check_eq("t1_ready", {31'd0, Byte_ready}, 32'd1);
    for (int i = 0; i < 6; i++) push_byte(t1[i], 1'b0);
    check_eq("t1_w0_en", {31'd0, Enable}, 32'd1);
    check_eq("t1_w0_addr", Address_in, 32'h10);
    check_eq("t1_w0_in", In, 32'h06280060);
    check_eq("t1_w0_rdy", {31'd0, Byte_ready}, 32'd0);
    tick();
    check_eq("t1_resume_en", {31'd0, Enable}, 32'd0);
    check_eq("t1_resume_rdy", {31'd0, Byte_ready}, 32'd1);
    for (int i = 6; i < 10; i++) push_byte(t1[i], 1'b0);
    check_eq("t1_w1_en", {31'd0, Enable}, 32'd1);
    check_eq("t1_w1_addr", Address_in, 32'h11);
    check_eq("t1_w1_in", In, 32'hE1000005);
`ifdef LOADER_CHECKSUM_EN
    tick();
    push_byte(8'hA8, 1'b0);
`else
    tick();
`endif
    check_eq("t1_done", {31'd0, Done}, 32'd1);
    check_eq("t1_done_hold", {31'd0, Cpu_hold}, 32'd0);
    check_eq("t1_err", {31'd0, Error}, 32'd0);
    check_eq("t1_cnt", 32'(Word_count), 32'd2);
    tick();
    check_eq("t1_done_off", {31'd0, Done}, 32'd0);
    check_eq("t1_idle_rdy", {31'd0, Byte_ready}, 32'd0);
    check_eq("t1_nwr", wr_addr.size(), 32'd2);

    // same load with a stuttering source
    clear_log();
    load(32'h10, t1, 1'b1);
    check_eq("t2_nwr", wr_addr.size(), 32'd2);
    check_wr("t2_w0", 0, 32'h10, 32'h06280060);
    check_wr("t2_w1", 1, 32'h11, 32'hE1000005);
    check_eq("t2_err", {31'd0, Error}, 32'd0);
    check_eq("t2_cnt", 32'(Word_count), 32'd2);
    tick();

    // length 257 overflows MAX_WORDS
    clear_log();
    do_start(32'h0);
    push_byte(8'h01, 1'b0);
    push_byte(8'h01, 1'b0);
    check_eq("t3_done", {31'd0, Done}, 32'd1);
    check_eq("t3_err", {31'd0, Error}, 32'd1);
    tick();
    check_eq("t3_done_off", {31'd0, Done}, 32'd0);
    check_eq("t3_rdy", {31'd0, Byte_ready}, 32'd0);
    check_eq("t3_err_sticky", {31'd0, Error}, 32'd1);
    check_eq("t3_nwr", wr_addr.size(), 32'd0);

    // zero-length load; new Start clears the old error
    do_start(32'h40);
    push_byte(8'h00, 1'b0);
    push_byte(8'h00, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    tick();
    push_byte(8'h00, 1'b0);
`endif
    check_eq("t0_done", {31'd0, Done}, 32'd1);
    check_eq("t0_err", {31'd0, Error}, 32'd0);
    check_eq("t0_cnt", 32'(Word_count), 32'd0);
    check_eq("t0_nwr", wr_addr.size(), 32'd0);
    tick();

    // reset after two bytes of the second word
    clear_log();
    do_start(32'h20);
    for (int i = 0; i < 8; i++) push_byte(t1[i], 1'b0);
    check_eq("t4_cnt_pre", 32'(Word_count), 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_eq("t4_en", {31'd0, Enable}, 32'd0);
    check_eq("t4_rw", {31'd0, RW_ram}, 32'd1);
    check_eq("t4_hold", {31'd0, Cpu_hold}, 32'd0);
    check_eq("t4_cnt", 32'(Word_count), 32'd0);
    check_eq("t4_rdy", {31'd0, Byte_ready}, 32'd0);
    check_eq("t4_nwr", wr_addr.size(), 32'd1);
    check_wr("t4_w0", 0, 32'h20, 32'h06280060);
    clear_log();
    load(32'h30, t1, 1'b0);
    check_wr("t4b_w0", 0, 32'h30, 32'h06280060);
    check_wr("t4b_w1", 1, 32'h31, 32'hE1000005);
    check_eq("t4b_err", {31'd0, Error}, 32'd0);
    check_eq("t4b_cnt", 32'(Word_count), 32'd2);
    tick();

`ifdef LOADER_CHECKSUM_EN
    // checksum good (0x09) and bad (0x00)
    clear_log();
    do_start(32'h50);
    foreach (t5[i]) push_byte(t5[i], 1'b0);
    tick();
    push_byte(8'h09, 1'b0);
    check_eq("t5_done", {31'd0, Done}, 32'd1);
    check_eq("t5_err", {31'd0, Error}, 32'd0);
    check_wr("t5_w0", 0, 32'h50, 32'h12345678);
    tick();
    clear_log();
    do_start(32'h50);
    foreach (t5[i]) push_byte(t5[i], 1'b0);
    tick();
    push_byte(8'h00, 1'b0);
    check_eq("t5b_done", {31'd0, Done}, 32'd1);
    check_eq("t5b_err", {31'd0, Error}, 32'd1);
    check_wr("t5b_w0", 0, 32'h50, 32'h12345678);
    tick();
`endif

    // address wrap across 2^32
    clear_log();
    load(32'hFFFFFFFF, t6, 1'b0);
    check_wr("t6_w0", 0, 32'hFFFFFFFF, 32'h11223344);
    check_wr("t6_w1", 1, 32'h00000000, 32'h55667788);
    check_eq("t6_err", {31'd0, Error}, 32'd0);
    tick();

    check_eq("port_safety", n_viol, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
